cpu_exec_ctrl: RTL and testbench
================================

// Module: cpu_exec_ctrl
// PURPOSE
//  Execution controller between the Nexys board inputs and the AVR cpu core: clean board-button events, a stretched core reset and a core clock-enable.
//  Sequences the core through reset, halt, free-run and single-step.
//  Sits in the board top level, in front of the cpu instance's reset pin and its clock-enable gating.
// PARAMETERS
//  DEBOUNCE_CYCLES   16'd50000  consecutive stable cycles before a button level is accepted (>=1)
//  RST_STRETCH       8'd16      cycles cpu_rst is held after any reset request (>=1)
//  STEP_CYCLES       4'd1       cpu_ce-high cycles granted per step request (>=1)
//  AUTO_RUN          1'b0       1: go RUN after reset hold, 0: go HALT
//  RST_ACTIVE_LEVEL  1'b1       asserted level of cpu_rst; matches the cpu's RST_ACTIVE_LEVEL
//  I_ADDR_WIDTH      10         width of pc / bp_addr (breakpoint option only)
// PORTS
//  clk        in   1             system clock (board oscillator)
//  reset      in   1             synchronous, active-high reset
//  btn_run    in   1             raw button, async; press toggles RUN/HALT
//  btn_step   in   1             raw button, async; press requests one step
//  btn_rst    in   1             raw button, async; press requests a core soft reset
//  cpu_rst    out  1             core reset, level RST_ACTIVE_LEVEL when asserted
//  cpu_ce     out  1             core clock enable, registered
//  state      out  2             00 RST_HOLD, 01 HALT, 10 RUN, 11 STEP
//  pc         in   I_ADDR_WIDTH  core program counter (breakpoint option only)
//  bp_addr    in   I_ADDR_WIDTH  breakpoint address (breakpoint option only)
//  bp_valid   in   1             breakpoint armed (breakpoint option only)
//  break_hit  out  1             sticky breakpoint flag (breakpoint option only)
// BEHAVIOUR
//  Reset: state=RST_HOLD, cpu_rst=RST_ACTIVE_LEVEL, cpu_ce=0, hold counter=RST_STRETCH-1, debounced levels=0, break_hit=0.
//  Button path, per button:
//   - 2-FF synchronizer.
//   - Counter counts cycles where the synced value differs from the debounced level; it clears on any agreeing cycle.
//   - At DEBOUNCE_CYCLES the debounced level flips and the counter clears.
//   - A 1-cycle press pulse is issued on each 0->1 flip of the debounced level. Releases produce no pulse.
//  FSM (all outputs registered from next state; cpu_ce = next_state in {RUN, STEP}):
//   - RST_HOLD: cpu_rst asserted, cpu_ce=0. The counter decrements; at 0 go RUN if AUTO_RUN, else HALT. cpu_rst deasserts on the same edge.
//   - HALT: run pulse -> RUN; step pulse -> STEP with step counter=STEP_CYCLES-1. Run and step together: run wins.
//   - RUN: run pulse -> HALT. Step pulses are ignored.
//   - STEP: cpu_ce high exactly STEP_CYCLES cycles, then HALT. Run and step pulses are ignored (dropped, not queued).
//   - A rst pulse in any state -> RST_HOLD, reloading the counter. It has priority over every other event; a rst pulse while in RST_HOLD restarts the stretch.
//   - reset mid-operation: immediate return to reset values on the next edge, all counters included.
//  Counters saturate; none wraps. A DEBOUNCE_CYCLES counter width of 16 is sufficient.
// CONFIGURATION
//  CPU_EXEC_CTRL_BREAK_EN defined:
//   - pc, bp_addr, bp_valid and break_hit ports exist.
//   - In RUN with cpu_ce=1, bp_valid=1 and pc==bp_addr, next state is HALT, so cpu_ce is 0 from the following cycle, and break_hit sets.
//   - break_hit clears on a run pulse, a rst pulse or reset.
//   - Break has priority over a same-cycle run pulse; rst pulse outranks break.
//   - The match is not checked in STEP.
//  Not defined: those four ports and all comparator logic are absent. Behaviour is otherwise identical.
// TESTING
//  (bench params: DEBOUNCE_CYCLES=4, RST_STRETCH=3, STEP_CYCLES=2, AUTO_RUN=0)
//  1. Reset 2 cycles, then release
//     -> cpu_rst=1 and state=00 for 3 cycles after release, then cpu_rst=0, state=01, cpu_ce=0.
//  2. From HALT, btn_run high 10 cycles
//     -> cpu_ce=1, state=10 exactly once, within 8 cycles of the edge. Bouncing btn_run 1-0-1 at 1-cycle spacing gives no transition.
//  3. From HALT, btn_step press -> cpu_ce=1 for exactly 2 cycles, then state=01.
//     A second press during STEP is dropped.
//  4. In RUN, btn_rst press -> state=00, cpu_rst asserted 3 cycles, then HALT.
//     Same for reset high 1 cycle mid-STEP.
//  5. run and step pulses in the same cycle while in HALT -> RUN.
//  6. BREAK_EN: bp_valid=1, bp_addr=10'h024, pc ramps in RUN
//     -> at pc==10'h024, cpu_ce=0 the next cycle and break_hit=1. A run press clears break_hit and resumes RUN.

Source files
------------

// File: rtl/cpu_exec_ctrl.sv
// Execution controller for the AVR core: debounced board buttons, stretched core reset,
// registered core clock-enable. Define CPU_EXEC_CTRL_BREAK_EN to add the PC breakpoint.
module cpu_exec_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd50000,
  parameter logic [7:0]  RST_STRETCH      = 8'd16,
  parameter logic [3:0]  STEP_CYCLES      = 4'd1,
  parameter logic        AUTO_RUN         = 1'b0,
  parameter logic        RST_ACTIVE_LEVEL = 1'b1
`ifdef CPU_EXEC_CTRL_BREAK_EN
  ,
  parameter int unsigned I_ADDR_WIDTH     = 10
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_rst,
  output logic       cpu_rst,
  output logic       cpu_ce,
  output logic [1:0] state
`ifdef CPU_EXEC_CTRL_BREAK_EN
  ,
  input  logic [I_ADDR_WIDTH-1:0] pc,
  input  logic [I_ADDR_WIDTH-1:0] bp_addr,
  input  logic                    bp_valid,
  output logic                    break_hit
`endif
);

  typedef enum logic [1:0] {
    StRstHold = 2'b00,
    StHalt    = 2'b01,
    StRun     = 2'b10,
    StStep    = 2'b11
  } state_e;

  // Button index: 0 run, 1 step, 2 rst.
  logic [2:0]  btn_raw;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  lvl_q, lvl_d;
  logic [2:0]  press_q, press_d;
  logic [15:0] db_cnt_q [3];
  logic [15:0] db_cnt_d [3];

  assign btn_raw = {btn_rst, btn_step, btn_run};

  always_comb begin
    lvl_d   = lvl_q;
    press_d = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] >= DEBOUNCE_CYCLES - 16'd1) begin
          lvl_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  logic run_p, step_p, rst_p;
  assign run_p  = press_q[0];
  assign step_p = press_q[1];
  assign rst_p  = press_q[2];

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] step_q, step_d;
  logic       cpu_rst_q, cpu_rst_d;
  logic       cpu_ce_q, cpu_ce_d;
  logic       hit_q, hit_d;
  logic       bp_hit;

`ifdef CPU_EXEC_CTRL_BREAK_EN
  assign bp_hit    = (state_q == StRun) && cpu_ce_q && bp_valid && (pc == bp_addr);
  assign break_hit = hit_q;
`else
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    step_d  = step_q;
    hit_d   = hit_q;
    if (rst_p) begin
      state_d = StRstHold;
      hold_d  = RST_STRETCH - 8'd1;
      hit_d   = 1'b0;
    end else begin
      unique case (state_q)
        StRstHold: begin
          if (hold_q == 8'd0) state_d = AUTO_RUN ? StRun : StHalt;
          else                hold_d  = hold_q - 8'd1;
        end
        StHalt: begin
          if (run_p) begin
            state_d = StRun;
          end else if (step_p) begin
            state_d = StStep;
            step_d  = STEP_CYCLES - 4'd1;
          end
        end
        StRun: begin
          if (bp_hit || run_p) state_d = StHalt;
        end
        StStep: begin
          if (step_q == 4'd0) state_d = StHalt;
          else                step_d  = step_q - 4'd1;
        end
      endcase
      // A breakpoint landing with a run press still halts and keeps the flag set.
      if (bp_hit)     hit_d = 1'b1;
      else if (run_p) hit_d = 1'b0;
    end
    cpu_rst_d = (state_d == StRstHold) ? RST_ACTIVE_LEVEL : ~RST_ACTIVE_LEVEL;
    cpu_ce_d  = (state_d == StRun) || (state_d == StStep);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      state_q   <= StRstHold;
      hold_q    <= RST_STRETCH - 8'd1;
      step_q    <= '0;
      cpu_rst_q <= RST_ACTIVE_LEVEL;
      cpu_ce_q  <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      press_q   <= press_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q   <= state_d;
      hold_q    <= hold_d;
      step_q    <= step_d;
      cpu_rst_q <= cpu_rst_d;
      cpu_ce_q  <= cpu_ce_d;
      hit_q     <= hit_d;
    end
  end

  assign cpu_rst = cpu_rst_q;
  assign cpu_ce  = cpu_ce_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Scoreboard bench for cpu_exec_ctrl: a cycle-level reference model pushes expected
// outputs each clock; a monitor pops and compares them on the falling edge.
module tb_cpu_exec_ctrl;

  localparam int DB = 4;
  localparam int RS = 3;
  localparam int SC = 2;

  logic       clk = 1'b0;
  logic       reset, btn_run, btn_step, btn_rst;
  logic       cpu_rst, cpu_ce;
  logic [1:0] state;
  logic       hit_obs;
`ifdef CPU_EXEC_CTRL_BREAK_EN
  logic [9:0] pc, bp_addr;
  logic       bp_valid, break_hit;
  assign hit_obs = break_hit;
`else
  assign hit_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_exec_ctrl #(
    .DEBOUNCE_CYCLES  (16'd4),
    .RST_STRETCH      (8'd3),
    .STEP_CYCLES      (4'd2),
    .AUTO_RUN         (1'b0),
    .RST_ACTIVE_LEVEL (1'b1)
`ifdef CPU_EXEC_CTRL_BREAK_EN
    ,
    .I_ADDR_WIDTH     (10)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .btn_rst  (btn_rst),
    .cpu_rst  (cpu_rst),
    .cpu_ce   (cpu_ce),
    .state    (state)
`ifdef CPU_EXEC_CTRL_BREAK_EN
    ,
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .break_hit (break_hit)
`endif
  );

  typedef struct packed {
    logic [1:0] st;
    logic       rst;
    logic       ce;
    logic       hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: modes 0 hold, 1 halt, 2 run, 3 step; remaining-cycle counters.
  initial begin
    int  mode, hold_left, step_left;
    int  streak[3];
    bit  lvl[3], pend[3], dly1[3], dly2[3], raw[3];
    bit  hit, brk, run_p, step_p, rst_p;
    exp_t e;
    mode = 0; hold_left = RS; step_left = 0; hit = 0;
    for (int b = 0; b < 3; b++) begin
      streak[b] = 0; lvl[b] = 0; pend[b] = 0; dly1[b] = 0; dly2[b] = 0;
    end
    forever begin
      @(posedge clk);
      raw[0] = btn_run; raw[1] = btn_step; raw[2] = btn_rst;
      if (reset) begin
        mode = 0; hold_left = RS; hit = 0;
        for (int b = 0; b < 3; b++) begin
          streak[b] = 0; lvl[b] = 0; pend[b] = 0; dly1[b] = 0; dly2[b] = 0;
        end
      end else begin
        run_p = pend[0]; step_p = pend[1]; rst_p = pend[2];
        brk = 0;
`ifdef CPU_EXEC_CTRL_BREAK_EN
        brk = (mode == 2) && bp_valid && (pc == bp_addr);
`endif
        if (rst_p) begin
          mode = 0; hold_left = RS; hit = 0;
        end else begin
          case (mode)
            0: begin hold_left--; if (hold_left == 0) mode = 1; end
            1: if (run_p) mode = 2; else if (step_p) begin mode = 3; step_left = SC; end
            2: if (brk || run_p) mode = 1;
            default: begin step_left--; if (step_left == 0) mode = 1; end
          endcase
          if (brk) hit = 1; else if (run_p) hit = 0;
        end
        for (int b = 0; b < 3; b++) begin
          pend[b] = 0;
          if (dly2[b] != lvl[b]) begin
            streak[b]++;
            if (streak[b] == DB) begin
              lvl[b] = dly2[b]; streak[b] = 0; pend[b] = dly2[b];
            end
          end else begin
            streak[b] = 0;
          end
          dly2[b] = dly1[b]; dly1[b] = raw[b];
        end
      end
      e.st  = 2'(mode);
      e.rst = (mode == 0);
      e.ce  = (mode == 2) || (mode == 3);
      e.hit = hit;
      exp_q.push_back(e);
    end
  end

  // Monitor
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, cpu_rst, cpu_ce, hit_obs};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t {state,rst,ce,hit}: got %b_%b_%b_%b want %b_%b_%b_%b",
                   $time, a.st, a.rst, a.ce, a.hit, e.st, e.rst, e.ce, e.hit);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input int which, input int hold, input int gap);
    if (which == 0) btn_run = 1'b1; else if (which == 1) btn_step = 1'b1; else btn_rst = 1'b1;
    tick(hold);
    if (which == 0) btn_run = 1'b0; else if (which == 1) btn_step = 1'b0; else btn_rst = 1'b0;
    tick(gap);
  endtask

  initial begin
    int w;
    reset = 1'b1; btn_run = 1'b0; btn_step = 1'b0; btn_rst = 1'b0;
`ifdef CPU_EXEC_CTRL_BREAK_EN
    pc = '0; bp_addr = '0; bp_valid = 1'b0;
`endif
    tick(2);
    n_tests++;
    if (cpu_rst !== 1'b1 || cpu_ce !== 1'b0 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL reset state t=%0t: rst=%b ce=%b state=%b", $time, cpu_rst, cpu_ce, state);
    end
    reset = 1'b0;
    w = 0;
    while (state !== 2'b01 && w < 20) begin
      tick(1);
      w++;
    end
    n_tests++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout t=%0t: HALT not reached after reset release", $time);
    end
    tick(2);
    // Run press, then a short bounce that must not toggle, then back to halt
    press(0, 10, 10);
    btn_run = 1'b1; tick(1); btn_run = 1'b0; tick(1); btn_run = 1'b1; tick(1);
    btn_run = 1'b0; tick(10);
    press(0, 10, 10);
    // Step; then step with run landing one cycle later (run dropped during step)
    press(1, 10, 10);
    btn_step = 1'b1; tick(1); btn_run = 1'b1; tick(10);
    btn_step = 1'b0; btn_run = 1'b0; tick(10);
    // Soft reset from run, and hard reset mid-step
    press(0, 6, 8);
    press(2, 6, 12);
    btn_step = 1'b1; tick(7);
    reset = 1'b1; tick(1);
    reset = 1'b0; btn_step = 1'b0; tick(10);
    // Run and step together from halt
    btn_run = 1'b1; btn_step = 1'b1; tick(8);
    btn_run = 1'b0; btn_step = 1'b0; tick(8);
`ifdef CPU_EXEC_CTRL_BREAK_EN
    bp_valid = 1'b1; bp_addr = 10'h024;
    for (int k = 'h1c; k < 'h2a; k++) begin
      pc = 10'(k); tick(1);
    end
    pc = '0; tick(2);
    press(0, 8, 8);
    bp_valid = 1'b0;
`endif
    // Random buttons with occasional hard reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0)  btn_run  = ~btn_run;
      if ($urandom_range(0, 4) == 0)  btn_step = ~btn_step;
      if ($urandom_range(0, 40) == 0) btn_rst  = ~btn_rst;
      reset = ($urandom_range(0, 300) == 0);
`ifdef CPU_EXEC_CTRL_BREAK_EN
      pc       = 10'h020 + 10'($urandom_range(0, 7));
      bp_valid = ($urandom_range(0, 3) != 0);
`endif
      tick(1);
    end
    reset = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_rst = 1'b0;
    tick(12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
